// File: rtl/ov7670_frame_transmitter_if.sv
// Camera-side bus of the frame transmitter: OV7670 pixel signalling plus the
// frame-buffer read port that feeds it.
interface ov7670_frame_transmitter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PXL_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 17
);
    logic                  o_PCLK;
    logic                  o_VS;
    logic                  o_HS;
    logic [DATA_WIDTH-1:0] o_DATA;
    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic [PXL_WIDTH-1:0]  i_rd_data;

    // Transmitter side: drives the camera pins and the read request.
    modport master (
        output o_PCLK,
        output o_VS,
        output o_HS,
        output o_DATA,
        output o_rd_en,
        output o_rd_addr,
        input  i_rd_data
    );

    // Receiver / frame-buffer side.
    modport slave (
        input  o_PCLK,
        input  o_VS,
        input  o_HS,
        input  o_DATA,
        input  o_rd_en,
        input  o_rd_addr,
        output i_rd_data
    );
endinterface

// File: rtl/ov7670_frame_transmitter.sv
// Replays a stored RGB565 frame as OV7670-style PCLK/VSYNC/HREF/DATA so the
// capture path can be exercised without a sensor. PCLK is clk/2 and every
// camera-pin update lands on the clk edge where PCLK falls.
module ov7670_frame_transmitter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned H_WIDTH    = 320,
    parameter int unsigned V_WIDTH    = 240,
    parameter int unsigned PXL_WIDTH  = 16,
    parameter int unsigned H_BLANK    = 144,
    parameter int unsigned VS_LINES   = 3,
    parameter int unsigned V_BACK     = 17,
    parameter int unsigned V_FRONT    = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_continuous,
    output logic o_busy,
    output logic o_frame_done,
    ov7670_frame_transmitter_if.master cam
);
    localparam int unsigned HREF_PCLKS = 2 * H_WIDTH;
    localparam int unsigned LINE_PCLKS = HREF_PCLKS + H_BLANK;
    localparam int unsigned PCNT_W     = (LINE_PCLKS > 1) ? $clog2(LINE_PCLKS) : 1;
    localparam int unsigned MAX_VA     = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int unsigned MAX_VB     = (V_WIDTH > V_FRONT) ? V_WIDTH : V_FRONT;
    localparam int unsigned MAX_LINES  = (MAX_VA > MAX_VB) ? MAX_VA : MAX_VB;
    localparam int unsigned LCNT_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int unsigned ADDR_W     = ((H_WIDTH * V_WIDTH) > 1) ? $clog2(H_WIDTH * V_WIDTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_V_BACK,
        ST_ACTIVE,
        ST_V_FRONT
    } state_t;

    state_t                state;
    state_t                nxt_state;
    logic [PCNT_W-1:0]     pcnt;
    logic [PCNT_W-1:0]     nxt_pcnt;
    logic [LCNT_W-1:0]     lcnt;
    logic [LCNT_W-1:0]     nxt_lcnt;
    logic [ADDR_W-1:0]     addr_cnt;
    logic [DATA_WIDTH-1:0] pixel_lo;
    logic                  pcnt_last;
    logic                  lcnt_last;
    logic                  frame_end;
    logic                  nxt_hs;
    logic                  rd_req;

    // Position of the PCLK period that starts at the next falling-edge update,
    // and whether that period must launch a pixel read.
    always_comb begin
        nxt_state = state;
        nxt_pcnt  = pcnt + PCNT_W'(1);
        nxt_lcnt  = lcnt;
        pcnt_last = (pcnt == PCNT_W'(LINE_PCLKS - 1));
        lcnt_last = 1'b0;

        case (state)
            ST_VSYNC:   lcnt_last = (lcnt == LCNT_W'(VS_LINES - 1));
            ST_V_BACK:  lcnt_last = (lcnt == LCNT_W'(V_BACK - 1));
            ST_ACTIVE:  lcnt_last = (lcnt == LCNT_W'(V_WIDTH - 1));
            ST_V_FRONT: lcnt_last = (lcnt == LCNT_W'(V_FRONT - 1));
            default:    lcnt_last = 1'b0;
        endcase

        if (pcnt_last) begin
            nxt_pcnt = '0;
            if (lcnt_last) begin
                nxt_lcnt = '0;
                case (state)
                    ST_VSYNC:   nxt_state = ST_V_BACK;
                    ST_V_BACK:  nxt_state = ST_ACTIVE;
                    ST_ACTIVE:  nxt_state = ST_V_FRONT;
                    ST_V_FRONT: nxt_state = i_continuous ? ST_VSYNC : ST_IDLE;
                    default:    nxt_state = ST_IDLE;
                endcase
            end else begin
                nxt_lcnt = lcnt + LCNT_W'(1);
            end
        end

        frame_end = (state == ST_V_FRONT) && pcnt_last && lcnt_last;
        nxt_hs    = (nxt_state == ST_ACTIVE) && (nxt_pcnt < PCNT_W'(HREF_PCLKS));

        // Read one period ahead of each high byte: inside the HREF phase for
        // pixels 1..H-1, and in the last period of the preceding line for pixel 0.
        rd_req = ((nxt_state == ST_ACTIVE) && nxt_pcnt[0]
                  && (nxt_pcnt < PCNT_W'(HREF_PCLKS - 1)))
              || ((nxt_pcnt == PCNT_W'(LINE_PCLKS - 1))
                  && (((nxt_state == ST_V_BACK) && (nxt_lcnt == LCNT_W'(V_BACK - 1)))
                   || ((nxt_state == ST_ACTIVE) && (nxt_lcnt != LCNT_W'(V_WIDTH - 1)))));
    end

    // Frame sequencer, PCLK divider and registered camera/read outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            pcnt          <= '0;
            lcnt          <= '0;
            addr_cnt      <= '0;
            pixel_lo      <= '0;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            cam.o_PCLK    <= 1'b0;
            cam.o_VS      <= 1'b0;
            cam.o_HS      <= 1'b0;
            cam.o_DATA    <= '0;
            cam.o_rd_en   <= 1'b0;
            cam.o_rd_addr <= '0;
        end else begin
            o_frame_done <= 1'b0;
            cam.o_rd_en  <= 1'b0;

            if (state == ST_IDLE) begin
                if (i_start) begin
                    state         <= ST_VSYNC;
                    pcnt          <= '0;
                    lcnt          <= '0;
                    addr_cnt      <= '0;
                    cam.o_rd_addr <= '0;
                    cam.o_VS      <= 1'b1;
                    o_busy        <= 1'b1;
                end
            end else begin
                cam.o_PCLK <= ~cam.o_PCLK;

                // PCLK falling edge: step to the next period and update the pins.
                if (cam.o_PCLK) begin
                    state        <= nxt_state;
                    pcnt         <= nxt_pcnt;
                    lcnt         <= nxt_lcnt;
                    o_busy       <= (nxt_state != ST_IDLE);
                    o_frame_done <= frame_end;
                    cam.o_VS     <= (nxt_state == ST_VSYNC);
                    cam.o_HS     <= nxt_hs;

                    if (nxt_hs) begin
                        if (!nxt_pcnt[0]) begin
                            cam.o_DATA <= i_rd_data_hi(cam.i_rd_data);
                            pixel_lo   <= cam.i_rd_data[DATA_WIDTH-1:0];
                        end else begin
                            cam.o_DATA <= pixel_lo;
                        end
                    end else begin
                        cam.o_DATA <= '0;
                    end

                    if (frame_end && (nxt_state == ST_VSYNC)) begin
                        addr_cnt      <= '0;
                        cam.o_rd_addr <= '0;
                    end

                    if (rd_req) begin
                        cam.o_rd_en   <= 1'b1;
                        cam.o_rd_addr <= addr_cnt;
                        addr_cnt      <= addr_cnt + ADDR_W'(1);
                    end
                end
            end
        end
    end

    // High byte of the pixel word as it arrives from the frame buffer.
    function automatic logic [DATA_WIDTH-1:0] i_rd_data_hi(input logic [PXL_WIDTH-1:0] pix);
        return pix[PXL_WIDTH-1 -: DATA_WIDTH];
    endfunction

endmodule

// File: tb/tb_ov7670_frame_transmitter.sv
// Directed bench for ov7670_frame_transmitter with a tiny 4x2 frame and a
// BRAM model returning 16'hA000 + address.
module tb_ov7670_frame_transmitter;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 16;
    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    logic i_reset;
    logic i_start;
    logic i_continuous;
    logic o_busy;
    logic o_frame_done;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] rd_q[$];
    logic [DW-1:0] rx_q[$];

    ov7670_frame_transmitter_if #(.DATA_WIDTH(DW), .PXL_WIDTH(PW), .ADDR_WIDTH(AW)) cam ();

    ov7670_frame_transmitter #(
        .DATA_WIDTH(DW), .H_WIDTH(4), .V_WIDTH(2), .PXL_WIDTH(PW),
        .H_BLANK(2), .VS_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_continuous (i_continuous),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .cam          (cam)
    );

    always #5 clk = ~clk;

    // Frame-buffer model and read-address log.
    always @(posedge clk) begin
        if (cam.o_rd_en) begin
            cam.i_rd_data <= 16'hA000 + 16'(cam.o_rd_addr);
            rd_q.push_back(cam.o_rd_addr);
        end
    end

    // Model receiver: samples the byte bus on PCLK rising edges during HREF.
    always @(posedge cam.o_PCLK) begin
        if (cam.o_HS) rx_q.push_back(cam.o_DATA);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pclk"},  32'(cam.o_PCLK),    32'd0);
        check({tag, "_vs"},    32'(cam.o_VS),      32'd0);
        check({tag, "_hs"},    32'(cam.o_HS),      32'd0);
        check({tag, "_data"},  32'(cam.o_DATA),    32'd0);
        check({tag, "_rd_en"}, 32'(cam.o_rd_en),   32'd0);
        check({tag, "_addr"},  32'(cam.o_rd_addr), 32'd0);
        check({tag, "_busy"},  32'(o_busy),        32'd0);
        check({tag, "_done"},  32'(o_frame_done),  32'd0);
    endtask

    // One non-continuous frame; optionally pulses i_start again at cycle extra_at.
    task automatic run_frame(input string tag, input int extra_at);
        int c;
        int vs_cyc;
        int hs_cyc;
        int done_at;
        int rd_base;
        int rx_base;
        int pix_bad;
        logic [15:0] pix;
        rd_base = rd_q.size();
        rx_base = rx_q.size();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check({tag, "_busy_rise"}, 32'(o_busy), 32'd1);
        check({tag, "_vs_rise"},   32'(cam.o_VS), 32'd1);
        check({tag, "_pclk_hold"}, 32'(cam.o_PCLK), 32'd0);
        c = 0;
        vs_cyc = 0;
        hs_cyc = 0;
        done_at = -1;
        while (c < 400) begin
            if (c == 1) check({tag, "_pclk_first"}, 32'(cam.o_PCLK), 32'd1);
            if (cam.o_VS) vs_cyc++;
            if (cam.o_HS) hs_cyc++;
            if (o_frame_done) begin
                done_at = c;
                break;
            end
            i_start = (c == extra_at);
            @(negedge clk);
            c++;
        end
        i_start = 1'b0;
        check({tag, "_done_cycle"}, 32'(done_at), 32'd100);
        check({tag, "_busy_end"},   32'(o_busy), 32'd0);
        check({tag, "_pclk_end"},   32'(cam.o_PCLK), 32'd0);
        check({tag, "_vs_cycles"},  32'(vs_cyc), 32'd20);
        check({tag, "_hs_cycles"},  32'(hs_cyc), 32'd32);
        check({tag, "_rd_pulses"},  32'(rd_q.size() - rd_base), 32'd8);
        check({tag, "_rx_bytes"},   32'(rx_q.size() - rx_base), 32'd16);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_addr%0d", tag, i), 32'(rd_q[rd_base + i]), 32'(i));
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_base + i]),
                  (i % 2 == 0) ? 32'hA0 : 32'(i / 2));
        pix_bad = 0;
        for (int p = 0; p < 8; p++) begin
            pix = {rx_q[rx_base + 2 * p], rx_q[rx_base + 2 * p + 1]};
            if (pix !== 16'hA000 + 16'(p)) pix_bad++;
        end
        check({tag, "_pixel_mismatches"}, 32'(pix_bad), 32'd0);
    endtask

    initial begin
        int c;
        int ndone;
        int busy_gap;
        int rd_base;
        int rx_base;
        int bad;
        int pclk_bad;
        int busy_bad;
        int rden_bad;
        logic [15:0] pix;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_continuous = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        i_reset = 1'b0;

        // Idle stability.
        pclk_bad = 0;
        busy_bad = 0;
        rden_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cam.o_PCLK !== 1'b0) pclk_bad++;
            if (o_busy !== 1'b0) busy_bad++;
            if (cam.o_rd_en !== 1'b0) rden_bad++;
        end
        check("idle_pclk", 32'(pclk_bad), 32'd0);
        check("idle_busy", 32'(busy_bad), 32'd0);
        check("idle_rd_en", 32'(rden_bad), 32'd0);

        run_frame("single", -1);
        repeat (5) @(negedge clk);
        run_frame("start_in_active", 50);
        repeat (5) @(negedge clk);

        // Continuous mode, three back-to-back frames.
        i_continuous = 1'b1;
        rd_base = rd_q.size();
        rx_base = rx_q.size();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        c = 0;
        ndone = 0;
        busy_gap = 0;
        while (ndone < 3 && c < 400) begin
            if (!o_busy) busy_gap++;
            @(negedge clk);
            c++;
            if (o_frame_done) begin
                ndone++;
                check($sformatf("cont_done%0d_cycle", ndone), 32'(c), 32'(100 * ndone));
                if (ndone < 3) begin
                    check($sformatf("cont_done%0d_vs", ndone), 32'(cam.o_VS), 32'd1);
                    check($sformatf("cont_done%0d_busy", ndone), 32'(o_busy), 32'd1);
                    check($sformatf("cont_done%0d_addr", ndone), 32'(cam.o_rd_addr), 32'd0);
                end else begin
                    check("cont_last_busy", 32'(o_busy), 32'd0);
                end
                if (ndone == 2) i_continuous = 1'b0;
            end
        end
        i_continuous = 1'b0;
        check("cont_done_count", 32'(ndone), 32'd3);
        check("cont_busy_gap", 32'(busy_gap), 32'd0);
        check("cont_rd_pulses", 32'(rd_q.size() - rd_base), 32'd24);
        bad = 0;
        for (int i = 0; i < 24; i++)
            if (32'(rd_q[rd_base + i]) !== 32'(i % 8)) bad++;
        check("cont_addr_mismatches", 32'(bad), 32'd0);
        bad = 0;
        for (int p = 0; p < 24; p++) begin
            pix = {rx_q[rx_base + 2 * p], rx_q[rx_base + 2 * p + 1]};
            if (pix !== 16'hA000 + 16'(p % 8)) bad++;
        end
        check("cont_pixel_mismatches", 32'(bad), 32'd0);
        repeat (5) @(negedge clk);

        // Reset in the middle of an HREF burst.
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        c = 0;
        while (!cam.o_HS && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("mid_rst_href_seen", 32'(cam.o_HS), 32'd1);
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check_all_zero("mid_rst");
        pclk_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cam.o_PCLK !== 1'b0 || o_busy !== 1'b0) pclk_bad++;
        end
        check("mid_rst_quiet", 32'(pclk_bad), 32'd0);
        run_frame("after_rst", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
